// File: rtl/mem_arbiter.sv
// Three-requester round-robin memory arbiter with per-grant burst limit.
// Accesses are steered combinationally from the owning requester; reads return one cycle later.
module mem_arbiter #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                    clock,
  input  logic                    nrst,
  input  logic [2:0]              req,
  input  logic [2:0]              wr_en,
  input  logic [3*WORD_WIDTH-1:0] addr_bus,
  input  logic [3*WORD_WIDTH-1:0] wdata_bus,
  output logic [2:0]              gnt,
  output logic [2:0]              rvalid,
  output logic [WORD_WIDTH-1:0]   rdata,
  output logic [WORD_WIDTH-1:0]   address,
  output logic                    mem_wr_en,
  output logic [WORD_WIDTH-1:0]   mem_data_in,
  input  logic [WORD_WIDTH-1:0]   mem_data_out
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, OWNED} state_e;

  state_e               state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           gnt_q, gnt_d;
  logic [2:0]           rvalid_q, rvalid_d;

  logic [3:0]           req_ext_c, wr_ext_c;
  logic [WORD_WIDTH-1:0] addr_a [4];
  logic [WORD_WIDTH-1:0] wdata_a [4];
  logic                 access_c;
  logic [1:0]           arb_base_c, pick_c;
  logic                 pick_vld_c;
  logic [1:0]           cand_c [3];
  logic                 release_c;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    inc3 = (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    onehot = 3'b001 << i;
  endfunction

  // Unpack per-requester buses; index 3 is a safe null slot.
  always_comb begin
    req_ext_c = {1'b0, req};
    wr_ext_c  = {1'b0, wr_en};
    for (int i = 0; i < 3; i++) begin
      addr_a[i]  = addr_bus[i*WORD_WIDTH +: WORD_WIDTH];
      wdata_a[i] = wdata_bus[i*WORD_WIDTH +: WORD_WIDTH];
    end
    addr_a[3]  = '0;
    wdata_a[3] = '0;
  end

  assign access_c = (state_q == OWNED) && req_ext_c[owner_q];

  // On release the search starts after the current owner, otherwise from ptr.
  always_comb begin
    arb_base_c = (state_q == OWNED) ? inc3(owner_q) : ptr_q;
    cand_c[0]  = arb_base_c;
    cand_c[1]  = inc3(arb_base_c);
    cand_c[2]  = inc3(cand_c[1]);
    pick_c     = arb_base_c;
    pick_vld_c = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (req_ext_c[cand_c[k]]) begin
        pick_c     = cand_c[k];
        pick_vld_c = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    release_c = 1'b0;
    rvalid_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld_c) begin
          state_d = OWNED;
          owner_d = pick_c;
          cnt_d   = '0;
        end
      end
      OWNED: begin
        if (!req_ext_c[owner_q]) begin
          release_c = 1'b1;
        end else begin
          if (!wr_ext_c[owner_q]) rvalid_d = onehot(owner_q);
          if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
            if ((req & ~onehot(owner_q)) != 3'b000) release_c = 1'b1;
            else cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (release_c) begin
          ptr_d = inc3(owner_q);
          cnt_d = '0;
          if (pick_vld_c) owner_d = pick_c;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == OWNED) ? onehot(owner_d) : 3'b000;
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q  <= IDLE;
      owner_q  <= 2'd0;
      ptr_q    <= 2'd0;
      cnt_q    <= '0;
      gnt_q    <= 3'b000;
      rvalid_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Memory returns data one cycle after the address, so rdata passes it through under rvalid.
  assign gnt         = gnt_q;
  assign rvalid      = rvalid_q;
  assign rdata       = (rvalid_q != 3'b000) ? mem_data_out : '0;
  assign address     = access_c ? addr_a[owner_q] : '0;
  assign mem_wr_en   = access_c & wr_ext_c[owner_q];
  assign mem_data_in = access_c ? wdata_a[owner_q] : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous one-cycle-latency memory model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        nrst;
  logic [2:0]  req, wr_en;
  logic [15:0] a0, a1, a2, d0, d1, d2;
  logic [47:0] addr_bus, wdata_bus;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata, address, mem_data_in, mem_data_out;
  logic        mem_wr_en;
  logic [15:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc;

  always #5 clock = ~clock;

  assign addr_bus  = {a2, a1, a0};
  assign wdata_bus = {d2, d1, d0};

  mem_arbiter #(.WORD_WIDTH(16), .MAX_BURST(8)) dut (
    .clock(clock), .nrst(nrst), .req(req), .wr_en(wr_en),
    .addr_bus(addr_bus), .wdata_bus(wdata_bus),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .address(address),
    .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always @(posedge clock) begin
    if (mem_wr_en) mem[address[7:0]] <= mem_data_in;
    mem_data_out <= mem[address[7:0]];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    nrst = 1'b0; req = '0; wr_en = '0;
    a0 = '0; a1 = '0; a2 = '0; d0 = '0; d1 = '0; d2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h10] = 16'h00AB;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_memwr", 32'(mem_wr_en), 32'h0);

    // Single read by requester 0
    nrst = 1'b1; req = 3'b001; a0 = 16'h0010; #1;
    chk("idle_addr", 32'(address), 32'h0);
    tick();
    chk("rd_gnt", 32'(gnt), 32'h1);
    chk("rd_addr", 32'(address), 32'h10);
    chk("rd_wr", 32'(mem_wr_en), 32'h0);
    tick();
    req = 3'b000; #1;
    chk("rd_rvalid", 32'(rvalid), 32'h1);
    chk("rd_rdata", 32'(rdata), 32'hAB);
    chk("drop_addr0", 32'(address), 32'h0);
    tick();
    chk("rel_gnt", 32'(gnt), 32'h0);
    chk("rel_rvalid", 32'(rvalid), 32'h0);

    // Write then read-back by requester 1
    req = 3'b010; wr_en = 3'b010; a1 = 16'h0020; d1 = 16'h1234; #1;
    tick();
    chk("wr_gnt", 32'(gnt), 32'h2);
    chk("wr_memwr", 32'(mem_wr_en), 32'h1);
    chk("wr_addr", 32'(address), 32'h20);
    chk("wr_data", 32'(mem_data_in), 32'h1234);
    tick();
    chk("wr_no_rvalid", 32'(rvalid), 32'h0);
    wr_en = 3'b000; #1;
    chk("rb_memwr", 32'(mem_wr_en), 32'h0);
    chk("rb_addr", 32'(address), 32'h20);
    tick();
    req = 3'b000; #1;
    chk("rb_rvalid", 32'(rvalid), 32'h2);
    chk("rb_rdata", 32'(rdata), 32'h1234);
    tick();
    chk("rb_rel", 32'(gnt), 32'h0);

    // Fairness: all three request from reset
    nrst = 1'b0; tick();
    nrst = 1'b1; req = 3'b111; a0 = 16'h0010; a1 = 16'h0011; a2 = 16'h0012;
    tick();
    for (int k = 0; k < 32; k++) begin
      chk("fair_gnt", 32'(gnt), 32'(3'b001 << ((k / 8) % 3)));
      if (k > 0) chk("fair_rvalid", 32'(rvalid), 32'(3'b001 << (((k - 1) / 8) % 3)));
      tick();
    end
    chk("fair_next", 32'(gnt), 32'h2);
    req = 3'b000; tick();
    chk("fair_idle", 32'(gnt), 32'h0);

    // Lone requester 2 keeps the grant across counter wraps
    req = 3'b100; tick();
    n_acc = 0;
    for (int k = 0; k < 20; k++) begin
      chk("lone_gnt", 32'(gnt), 32'h4);
      chk("lone_addr", 32'(address), 32'h12);
      if (address == 16'h0012) n_acc++;
      tick();
    end
    chk("lone_acc", 32'(n_acc), 32'd20);
    chk("lone_hold", 32'(gnt), 32'h4);
    req = 3'b000; tick();
    chk("lone_idle", 32'(gnt), 32'h0);

    // Early drop by owner 0 while requester 1 waits
    req = 3'b011; tick();
    for (int k = 0; k < 3; k++) begin
      chk("ed_gnt0", 32'(gnt), 32'h1);
      tick();
    end
    req = 3'b010; #1;
    chk("ed_drop_gnt", 32'(gnt), 32'h1);
    chk("ed_drop_addr", 32'(address), 32'h0);
    chk("ed_drop_wr", 32'(mem_wr_en), 32'h0);
    tick();
    chk("ed_handoff", 32'(gnt), 32'h2);
    req = 3'b101; #1;
    chk("ed_drop1_addr", 32'(address), 32'h0);
    tick();
    chk("ed_rr_pick2", 32'(gnt), 32'h4);
    req = 3'b000; tick();
    chk("ed_idle", 32'(gnt), 32'h0);

    // Pointer wrapped from 2 to 0; then reset with a read outstanding
    req = 3'b011; tick();
    chk("wrap_pick0", 32'(gnt), 32'h1);
    tick();
    nrst = 1'b0; tick();
    chk("mr_gnt", 32'(gnt), 32'h0);
    chk("mr_rvalid", 32'(rvalid), 32'h0);
    chk("mr_rdata", 32'(rdata), 32'h0);
    nrst = 1'b1; req = 3'b110; tick();
    chk("mr_regnt", 32'(gnt), 32'h2);
    chk("mr_rvalid2", 32'(rvalid), 32'h0);
    req = 3'b000; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default 16, sets the width of the address and data words.
REQ-002 Parameter MAX_BURST, default 8, sets the maximum number of consecutive accesses per grant while another requester waits.
REQ-003 Port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port nrst, input, 1, reset; synchronous and active-low.
REQ-005 Port req, input, 3, per-requester access request; bit i belongs to requester i (0 = winnerPolicy, 1 and 2 = other clients).
REQ-006 Port wr_en, input, 3, per-requester write strobe; 1 = write, 0 = read.
REQ-007 Port addr_bus, input, 3*WORD_WIDTH, requester i address in bits [16i+15:16i].
REQ-008 Port wdata_bus, input, 3*WORD_WIDTH, requester i write data in bits [16i+15:16i].
REQ-009 Port gnt, output, 3, registered one-hot grant; all-zero when idle.
REQ-010 Port rvalid, output, 3, registered one-hot read-data-valid strobe.
REQ-011 Port rdata, output, WORD_WIDTH, read data broadcast to all requesters; qualified by rvalid.
REQ-012 Port address, output, WORD_WIDTH, memory address.
REQ-013 Port mem_wr_en, output, 1, memory write enable.
REQ-014 Port mem_data_in, output, WORD_WIDTH, memory write data.
REQ-015 Port mem_data_out, input, WORD_WIDTH, memory read data; valid one cycle after the address is presented.

Function
REQ-016 The block SHALL use two states: IDLE (gnt = 000) and OWNED (exactly one gnt bit set, owner index held in a register).
REQ-017 Access rule: in any cycle with gnt[i]=1 and req[i]=1, the block SHALL drive address, mem_wr_en and mem_data_in combinationally from addr_bus[i], wr_en[i] and wdata_bus[i]; that cycle performs exactly one access.
REQ-018 In any cycle without an access, the block SHALL drive mem_wr_en=0 and address and mem_data_in to 0.
REQ-019 Read return: a read access by requester i in cycle t SHALL produce rvalid[i]=1 in cycle t+1, with rdata=mem_data_out; otherwise rvalid=000 and rdata is don't-care.
REQ-020 Arbitration: from IDLE, or on release from OWNED, the block SHALL select the first asserted req bit searching round-robin from pointer ptr (order ptr, ptr+1, ptr+2, wrapping mod 3).
REQ-021 Grant latency: gnt SHALL assert in the cycle after the selecting req sample; there is no idle gap on a direct handoff between owners.
REQ-022 On release, ptr SHALL become (owner+1) mod 3; the wrap from 2 goes to 0.
REQ-023 Release, case 1: if req[owner]=0 while in OWNED, the block SHALL perform no access that cycle and SHALL re-arbitrate (IDLE if no req, else new owner next cycle).
REQ-024 Burst counter cnt (width ceil(log2 MAX_BURST)+1) SHALL reset to 0 on every new grant and increment on each access.
REQ-025 Release, case 2: when the access bringing cnt to MAX_BURST occurs and any other req bit is set, the block SHALL release after that access.
REQ-026 When cnt reaches MAX_BURST with no other requester pending, the owner SHALL retain the grant and cnt SHALL restart at 0.
REQ-027 Simultaneous requests from IDLE SHALL be resolved solely by ptr; after reset, ptr=0.
REQ-028 A requester SHALL keep req, wr_en, addr and wdata stable until gnt is seen; the arbiter does not buffer requests.

Reset
REQ-029 When nrst=0 at a rising edge, the block SHALL set gnt=000, rvalid=000, rdata=0, ptr=0, cnt=0 and state IDLE.
REQ-030 If reset occurs mid-burst or with a read outstanding, the block SHALL suppress the pending rvalid and resume arbitration from ptr=0 on the first edge with nrst=1.

Verification
REQ-031 Read: after reset, req=001, wr_en=0, addr0=0x0010, memory[0x0010]=0x00AB -> gnt=001 next cycle; rvalid=001 and rdata=0x00AB one cycle after the access.
REQ-032 Write: req=010, wr_en=010, addr1=0x0020, wdata1=0x1234 -> mem_wr_en=1 and address=0x0020 in the grant cycle; a later read of 0x0020 returns 0x1234.
REQ-033 Fairness: req=111 held from reset with MAX_BURST=8 -> grants of 8 accesses each in order 0,1,2,0, with no idle cycle between owners.
REQ-034 Lone requester: req=100 held for 20 cycles -> gnt=100 continuously, 20 accesses, and cnt wraps without releasing.
REQ-035 Early drop: owner 0 drops req after 3 accesses while req[1]=1 -> no access in the drop cycle; gnt=010 next cycle; ptr=1.
REQ-036 Reset mid-read: nrst=0 in the cycle after a read access -> rvalid stays 000, gnt=000; after release with req=110, the next grant is 010.
